// File: rtl/alu_issue.sv
// ID->EX ALU issue stage: decodes an RV32I instruction into ALU control and operands,
// then registers the entry behind a valid/ready handshake with a one-entry skid buffer.
module alu_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_opr1,
  output logic [XLEN-1:0] out_opr2,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] opr1;
    logic [XLEN-1:0] opr2;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt_i, shamt_r;
  logic            legal, wb;
  entry_t          dec;

  assign opcode  = in_instr[6:0];
  assign rd      = in_instr[11:7];
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];
  assign imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u   = {in_instr[31:12], 12'b0};
  assign shamt_i = {27'b0, in_instr[24:20]};
  // Register shifts pass only the low five bits: the ALU shifter consumes all of opr2.
  assign shamt_r = {27'b0, in_rs2_data[4:0]};

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.rd    = rd;
    dec.opr1  = in_rs1_data;
    dec.opr2  = in_rs2_data;
    legal     = 1'b1;
    wb        = 1'b0;
    case (opcode)
      OpcOp: begin
        dec.ctrl = {f7[5], f3};
        if (f3 == 3'b001 || f3 == 3'b101) dec.opr2 = shamt_r;
        legal = (f7 == 7'b0000000) ||
                (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        wb    = 1'b1;
      end
      OpcOpImm: begin
        dec.ctrl = {1'b0, f3};
        dec.opr2 = imm_i;
        if (f3 == 3'b001) begin
          dec.opr2 = shamt_i;
          legal    = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          dec.opr2 = shamt_i;
          dec.ctrl = {in_instr[30], 3'b101};
          legal    = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end
        wb = 1'b1;
      end
      OpcLoad: begin
        dec.opr2 = imm_i;
        wb       = 1'b1;
      end
      OpcStore: dec.opr2 = imm_s;
      OpcBranch: begin
        case (f3)
          3'b000, 3'b001: dec.ctrl = 4'b1000;
          3'b100, 3'b101: dec.ctrl = 4'b0010;
          3'b110, 3'b111: dec.ctrl = 4'b0011;
          default:        legal    = 1'b0;
        endcase
      end
      OpcLui: begin
        dec.opr1 = '0;
        dec.opr2 = imm_u;
        wb       = 1'b1;
      end
      OpcAuipc: begin
        dec.opr1 = in_pc;
        dec.opr2 = imm_u;
        wb       = 1'b1;
      end
      OpcJal, OpcJalr: begin
        dec.opr1 = in_pc;
        dec.opr2 = 32'd4;
        legal    = (opcode == OpcJal) || (f3 == 3'b000);
        wb       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec.wb_en = wb & (rd != 5'd0);
    if (!legal) begin
      dec.ctrl    = 4'b0000;
      dec.opr1    = '0;
      dec.opr2    = '0;
      dec.wb_en   = 1'b0;
      dec.illegal = 1'b1;
    end
  end

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   in_xfer, out_free;

  assign in_ready = ~rst & ~skid_valid_q;
  assign in_xfer  = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // in_ready is low whenever the skid holds an entry, so the two never collide.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_xfer;
        if (in_xfer) out_d = dec;
      end
    end else if (in_xfer) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_alu_ctrl = out_q.ctrl;
  assign out_opr1     = out_q.opr1;
  assign out_opr2     = out_q.opr2;
  assign out_rd       = out_q.rd;
  assign out_wb_en    = out_q.wb_en;
  assign out_illegal  = out_q.illegal;
  assign out_pc       = out_q.pc;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vector table plus backpressure, flush and reset sequences.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [3:0]  out_alu_ctrl;
  logic [31:0] out_opr1, out_opr2, out_pc;
  logic [4:0]  out_rd;
  logic        out_wb_en, out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_opr1     (out_opr1),
    .out_opr2     (out_opr2),
    .out_rd       (out_rd),
    .out_wb_en    (out_wb_en),
    .out_illegal  (out_illegal),
    .out_pc       (out_pc)
  );

  typedef struct {
    string       name;
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  ctrl;
    logic [31:0] opr1, opr2;
    logic [4:0]  rd;
    logic        wb, ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input vec_t v);
    chk({v.name, " valid"}, 32'(out_valid), 32'd1);
    chk({v.name, " ctrl"}, 32'(out_alu_ctrl), 32'(v.ctrl));
    chk({v.name, " opr1"}, out_opr1, v.opr1);
    chk({v.name, " opr2"}, out_opr2, v.opr2);
    chk({v.name, " rd"}, 32'(out_rd), 32'(v.rd));
    chk({v.name, " wb_en"}, 32'(out_wb_en), 32'(v.wb));
    chk({v.name, " illegal"}, 32'(out_illegal), 32'(v.ill));
    chk({v.name, " pc"}, out_pc, v.pc);
  endtask

  task automatic drive(input vec_t v);
    in_valid    = 1'b1;
    in_instr    = v.instr;
    in_pc       = v.pc;
    in_rs1_data = v.rs1;
    in_rs2_data = v.rs2;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t find(input string nm);
    foreach (vecs[i]) if (vecs[i].name == nm) return vecs[i];
    return vecs[0];
  endfunction

  // Loads two entries while EX stalls: first into the output register, second into the skid.
  task automatic fill_two(input vec_t a, input vec_t b);
    @(negedge clk);
    out_ready = 1'b0;
    drive(a);
    edge_sample();
    @(negedge clk);
    drive(b);
    edge_sample();
  endtask

  initial begin
    //        name      instr         pc            rs1           rs2           ctrl     opr1          opr2          rd  wb ill
    vecs.push_back('{"add",    32'h002081B3, 32'h00000100, 32'h00000005, 32'h00000007, 4'b0000, 32'h00000005, 32'h00000007, 5'd3, 1, 0});
    vecs.push_back('{"sub",    32'h402081B3, 32'h00000104, 32'h00000009, 32'h00000002, 4'b1000, 32'h00000009, 32'h00000002, 5'd3, 1, 0});
    vecs.push_back('{"srai",   32'h40435293, 32'h00000108, 32'h80000000, 32'hDEADBEEF, 4'b1101, 32'h80000000, 32'h00000004, 5'd5, 1, 0});
    vecs.push_back('{"sra",    32'h407352B3, 32'h0000010C, 32'h80000000, 32'h00000124, 4'b1101, 32'h80000000, 32'h00000004, 5'd5, 1, 0});
    vecs.push_back('{"addi",   32'hFFF00093, 32'h00000110, 32'h00000011, 32'h00000000, 4'b0000, 32'h00000011, 32'hFFFFFFFF, 5'd1, 1, 0});
    vecs.push_back('{"lui",    32'h12345137, 32'h00000114, 32'hAAAAAAAA, 32'h55555555, 4'b0000, 32'h00000000, 32'h12345000, 5'd2, 1, 0});
    vecs.push_back('{"beq",    32'h00208063, 32'h00000118, 32'h00000001, 32'h00000002, 4'b1000, 32'h00000001, 32'h00000002, 5'd0, 0, 0});
    vecs.push_back('{"bge",    32'h0020D063, 32'h0000011C, 32'h00000003, 32'h00000004, 4'b0010, 32'h00000003, 32'h00000004, 5'd0, 0, 0});
    vecs.push_back('{"bltu",   32'h0020E063, 32'h00000120, 32'h00000005, 32'h00000006, 4'b0011, 32'h00000005, 32'h00000006, 5'd0, 0, 0});
    vecs.push_back('{"br010",  32'h0020A063, 32'h00000124, 32'h00000005, 32'h00000006, 4'b0000, 32'h00000000, 32'h00000000, 5'd0, 0, 1});
    vecs.push_back('{"opc7f",  32'h000000FF, 32'h00000128, 32'h12345678, 32'h9ABCDEF0, 4'b0000, 32'h00000000, 32'h00000000, 5'd1, 0, 1});
    vecs.push_back('{"mul",    32'h022081B3, 32'h0000012C, 32'h00000003, 32'h00000004, 4'b0000, 32'h00000000, 32'h00000000, 5'd3, 0, 1});
    vecs.push_back('{"slli7",  32'h40309093, 32'h00000130, 32'h00000003, 32'h00000004, 4'b0000, 32'h00000000, 32'h00000000, 5'd1, 0, 1});
    vecs.push_back('{"addix0", 32'h00500013, 32'h00000134, 32'h00000007, 32'h00000000, 4'b0000, 32'h00000007, 32'h00000005, 5'd0, 0, 0});
    vecs.push_back('{"auipc",  32'h80000217, 32'h00001000, 32'h00000001, 32'h00000002, 4'b0000, 32'h00001000, 32'h80000000, 5'd4, 1, 0});
    vecs.push_back('{"jal",    32'h000000EF, 32'h00002000, 32'h00000001, 32'h00000002, 4'b0000, 32'h00002000, 32'h00000004, 5'd1, 1, 0});
    vecs.push_back('{"jalr",   32'h000100E7, 32'h00003000, 32'h00000001, 32'h00000002, 4'b0000, 32'h00003000, 32'h00000004, 5'd1, 1, 0});
    vecs.push_back('{"jalr001",32'h000110E7, 32'h00003004, 32'h00000001, 32'h00000002, 4'b0000, 32'h00000000, 32'h00000000, 5'd1, 0, 1});
    vecs.push_back('{"sw",     32'hFE20AE23, 32'h00004000, 32'h00000100, 32'h00000002, 4'b0000, 32'h00000100, 32'hFFFFFFFC, 5'd28, 0, 0});
    vecs.push_back('{"lw",     32'h0080A283, 32'h00004004, 32'h00000200, 32'h00000002, 4'b0000, 32'h00000200, 32'h00000008, 5'd5, 1, 0});

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    repeat (2) edge_sample();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset opr1", out_opr1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    // Decode table, one entry at a time with EX always ready.
    foreach (vecs[i]) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(vecs[i]);
      edge_sample();
      chk_out(vecs[i]);
      chk({vecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
    end
    edge_sample();
    chk("drained out_valid", 32'(out_valid), 32'd0);

    // Backpressure: ADDI to output, LUI to skid, BEQ held upstream.
    fill_two(find("addi"), find("lui"));
    @(negedge clk);
    drive(find("beq"));
    #1;
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    chk_out(find("addi"));
    edge_sample();
    chk_out(find("addi"));
    @(negedge clk);
    out_ready = 1'b1;
    edge_sample();
    chk_out(find("lui"));
    chk("bp in_ready reopens", 32'(in_ready), 32'd1);
    edge_sample();
    chk_out(find("beq"));
    @(negedge clk);
    in_valid = 1'b0;
    edge_sample();
    chk("bp drained", 32'(out_valid), 32'd0);

    // Flush with output and skid occupied and a new input presented.
    fill_two(find("add"), find("sub"));
    @(negedge clk);
    flush = 1'b1;
    drive(find("jal"));
    edge_sample();
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      edge_sample();
      chk($sformatf("flush quiet %0d", c), 32'(out_valid), 32'd0);
    end

    // Reset mid-stall with skid full.
    fill_two(find("lw"), find("auipc"));
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    edge_sample();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst opr2", out_opr2, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    edge_sample();
    chk("after rst in_ready", 32'(in_ready), 32'd1);
    chk("after rst out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
